// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, enable levels and
// the IF state encodings.
package if_fetch_pkg;

    localparam int REG_BUS      = 32;
    localparam int INST_BUS     = 32;
    localparam int MEM_BYTE_BUS = 8;
    localparam int INST_BYTES   = INST_BUS / MEM_BYTE_BUS;

    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

    localparam logic ENABLED  = 1'b1;
    localparam logic DISABLED = 1'b0;

    localparam logic [1:0] IF_IDLE  = 2'd0;
    localparam logic [1:0] IF_FETCH = 2'd1;
    localparam logic [1:0] IF_DONE  = 2'd2;

    typedef logic [MEM_BYTE_BUS-1:0] mem_byte_t;

    // Little-endian assembly of four bytes, b0 at the lowest address.
    function automatic logic [INST_BUS-1:0] pack_le(
        input mem_byte_t b3,
        input mem_byte_t b2,
        input mem_byte_t b1,
        input mem_byte_t b0
    );
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: reads one instruction as four bytes over
// the shared byte port and hands {inst, pc, valid} to decode.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              branch_flag_i,
    input  logic              id_stall_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_a_o,
    input  logic              mem_gnt_i,
    input  logic [7:0]        mem_din_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    output logic              stallreq_o
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] fpc;
    logic [2:0]        issue_cnt;
    logic [1:0]        recv_cnt;
    logic              pending;
    logic [23:0]       byte_q;
    logic              req_fire;

    always_comb begin
        mem_req_o  = DISABLED;
        mem_a_o    = '0;
        stallreq_o = DISABLED;
        if (state == IF_FETCH) begin
            stallreq_o = ENABLED;
            if (issue_cnt < 3'd4) begin
                mem_req_o = ENABLED;
                mem_a_o   = fpc + ADDR_W'(issue_cnt);
            end
        end
    end

    assign req_fire = mem_req_o && mem_gnt_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IF_IDLE;
            fpc          <= '0;
            issue_cnt    <= '0;
            recv_cnt     <= '0;
            pending      <= DISABLED;
            byte_q       <= '0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= DISABLED;
        end else if (branch_flag_i) begin
            // Clearing pending drops the byte still in flight.
            state        <= IF_IDLE;
            issue_cnt    <= '0;
            recv_cnt     <= '0;
            pending      <= DISABLED;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= DISABLED;
        end else begin
            unique case (1'b1)
                (state == IF_IDLE): begin
                    pending <= DISABLED;
                    if (ce_i) begin
                        fpc       <= pc_i;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        state     <= IF_FETCH;
                    end
                end
                (state == IF_FETCH): begin
                    pending <= req_fire;
                    if (req_fire) begin
                        issue_cnt <= issue_cnt + 3'd1;
                    end
                    if (pending) begin
                        recv_cnt <= recv_cnt + 2'd1;
                        // Bytes shift in from the top so b0 ends lowest.
                        byte_q   <= {mem_din_i, byte_q[23:8]};
                        if (recv_cnt == 2'd3) begin
                            inst_o       <= INST_W'(pack_le(mem_din_i,
                                                            byte_q[23:16],
                                                            byte_q[15:8],
                                                            byte_q[7:0]));
                            inst_pc_o    <= fpc;
                            inst_valid_o <= ENABLED;
                            state        <= IF_DONE;
                        end
                    end
                end
                (state == IF_DONE): begin
                    pending <= DISABLED;
                    if (!id_stall_i) begin
                        inst_o       <= '0;
                        inst_pc_o    <= '0;
                        inst_valid_o <= DISABLED;
                        state        <= IF_IDLE;
                    end
                end
                default: begin
                    state        <= IF_IDLE;
                    pending      <= DISABLED;
                    inst_valid_o <= DISABLED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized
// fetches checked against a byte-memory reference model.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = '0;
    logic        ce_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic        id_stall_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_a_o;
    logic        mem_gnt_i = 1'b0;
    logic [7:0]  mem_din_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        stallreq_o;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] mem_init [logic [31:0]];

    always #5 clk = ~clk;

    if_fetch #(.ADDR_W(32), .INST_W(32)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i),
        .branch_flag_i(branch_flag_i), .id_stall_i(id_stall_i),
        .mem_req_o(mem_req_o), .mem_a_o(mem_a_o),
        .mem_gnt_i(mem_gnt_i), .mem_din_i(mem_din_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .inst_valid_o(inst_valid_o), .stallreq_o(stallreq_o)
    );

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        logic [7:0] lo;
        if (mem_init.exists(a)) return mem_init[a];
        lo = a[7:0] * 8'd37;
        return lo ^ a[15:8] ^ a[31:24] ^ 8'h5a;
    endfunction

    function automatic logic [31:0] ref_inst(input logic [31:0] pc);
        return {mem_rd(pc + 32'd3), mem_rd(pc + 32'd2),
                mem_rd(pc + 32'd1), mem_rd(pc)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Ends the current cycle; memory answers a granted read one cycle later.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        g = mem_req_o && mem_gnt_i;
        a = mem_a_o;
        @(posedge clk);
        #1;
        mem_din_i = (g === 1'b1) ? mem_rd(a) : 8'($urandom);
    endtask

    // One fetch from IDLE: accept cycle is cycle 0. gap[c]=1 withholds grant.
    task automatic run_fetch(input logic [31:0] pc, input logic [63:0] gap,
                             input bit rnd, input int stall_n,
                             input bit fl, output int vc);
        int  ng, e4;
        bit  bad_a, bad_s, bad_v, bad_h;
        logic [31:0] ei;
        ei = ref_inst(pc);
        pc_i = pc; ce_i = 1'b1; mem_gnt_i = 1'b1;
        branch_flag_i = 1'b0; id_stall_i = 1'b0;
        tick();
        ng = 0; e4 = -100; vc = -1;
        bad_a = 0; bad_s = 0; bad_v = 0; bad_h = 0;
        for (int c = 1; c <= 60; c++) begin
            mem_gnt_i = rnd ? ($urandom_range(0, 3) != 0) : !gap[c];
            ce_i = 1'($urandom_range(0, 1));
            pc_i = $urandom;
            if (inst_valid_o && mem_req_o) bad_v = 1;
            if (inst_valid_o) begin
                vc = c;
                break;
            end
            if (stallreq_o !== 1'b1) bad_s = 1;
            if (mem_req_o) begin
                if (mem_a_o !== pc + 32'(ng)) bad_a = 1;
                if (mem_gnt_i) begin
                    ng++;
                    if (ng == 4) e4 = c;
                end
            end
            tick();
        end
        check("fetch_timeout", 32'(vc > 0), 32'd1);
        if (vc < 0) return;
        check("valid_latency", 32'(vc), 32'(e4 + 2));
        check("grant_count", 32'(ng), 32'd4);
        check("addr_seq", 32'(bad_a), 32'd0);
        check("stall_in_fetch", 32'(bad_s), 32'd0);
        check("valid_with_req", 32'(bad_v), 32'd0);
        check("inst", inst_o, ei);
        check("inst_pc", inst_pc_o, pc);
        check("done_stallreq", 32'(stallreq_o), 32'd0);
        check("done_req", 32'(mem_req_o), 32'd0);
        id_stall_i = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
            mem_gnt_i = 1'($urandom);
            tick();
            if (inst_o !== ei || inst_pc_o !== pc || inst_valid_o !== 1'b1
                || mem_req_o !== 1'b0 || stallreq_o !== 1'b0) bad_h = 1;
        end
        check("id_stall_hold", 32'(bad_h), 32'd0);
        if (fl) begin
            branch_flag_i = 1'b1;
            tick();
            branch_flag_i = 1'b0;
            id_stall_i = 1'b0;
            check("flush_done_valid", 32'(inst_valid_o), 32'd0);
        end else begin
            id_stall_i = 1'b0;
            ce_i = 1'b0;
            tick();
            check("consume_valid", 32'(inst_valid_o), 32'd0);
            check("idle_stallreq", 32'(stallreq_o), 32'd0);
        end
        ce_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vc;
        mem_init[32'h0000_1000] = 8'h13;
        mem_init[32'h0000_1001] = 8'h05;
        mem_init[32'h0000_1002] = 8'h10;
        mem_init[32'h0000_1003] = 8'h00;

        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_addr", mem_a_o, 32'd0);
        check("rst_stallreq", 32'(stallreq_o), 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_inst_pc", inst_pc_o, 32'd0);
        rst = 1'b0;

        // Basic fetch with continuous grant.
        run_fetch(32'h0000_1000, 64'd0, 1'b0, 0, 1'b0, vc);
        check("basic_cycle", 32'(vc), 32'd6);
        check("basic_ref", ref_inst(32'h1000), 32'h0010_0513);

        // Grant withheld in cycles 2 and 3.
        run_fetch(32'h0000_1000, 64'h0c, 1'b0, 0, 1'b0, vc);
        check("gap_cycle", 32'(vc), 32'd8);

        // Decode stall for 5 cycles after DONE.
        run_fetch(32'h0000_1000, 64'd0, 1'b0, 5, 1'b0, vc);

        // Flush in cycle 3; the byte returning in cycle 4 is dropped.
        pc_i = 32'h0000_1000; ce_i = 1'b1; mem_gnt_i = 1'b1;
        tick();
        ce_i = 1'b0;
        tick();
        tick();
        branch_flag_i = 1'b1;
        tick();
        branch_flag_i = 1'b0;
        check("flush_req", 32'(mem_req_o), 32'd0);
        check("flush_stallreq", 32'(stallreq_o), 32'd0);
        check("flush_valid", 32'(inst_valid_o), 32'd0);
        run_fetch(32'h0000_2000, 64'd0, 1'b0, 0, 1'b0, vc);

        // Reset asserted in cycle 4 of a fetch.
        pc_i = 32'h0000_3000; ce_i = 1'b1; mem_gnt_i = 1'b1;
        tick();
        ce_i = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mrst_req", 32'(mem_req_o), 32'd0);
        check("mrst_addr", mem_a_o, 32'd0);
        check("mrst_stallreq", 32'(stallreq_o), 32'd0);
        check("mrst_valid", 32'(inst_valid_o), 32'd0);
        check("mrst_inst", inst_o, 32'd0);
        check("mrst_inst_pc", inst_pc_o, 32'd0);
        rst = 1'b0;
        run_fetch(32'h0000_3000, 64'd0, 1'b0, 0, 1'b0, vc);
        check("mrst_cycle", 32'(vc), 32'd6);

        // Address wrap-around.
        run_fetch(32'hffff_fffe, 64'd0, 1'b0, 0, 1'b0, vc);

        // Flush while decode is stalled in DONE.
        run_fetch(32'h0000_4000, 64'd0, 1'b0, 2, 1'b1, vc);

        for (int i = 0; i < 10; i++) begin
            run_fetch($urandom, 64'd0, 1'b1, $urandom_range(0, 4),
                      1'($urandom_range(0, 1)), vc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly downstream of pc_reg. Takes the current pc and fetch enable, reads the 32-bit instruction as four bytes over the shared 8-bit memory port, and presents {inst, pc, valid} to decode.
- Raises a stall request to the pipeline controller while a fetch is in flight, so pc_reg holds pc.
- Aborts the current fetch on a taken branch.

Parameters:
- ADDR_W, 32, width of pc and memory byte address.
- INST_W, 32, instruction width. Fixed at 4 bytes; any other value is unsupported.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- pc_i  in  ADDR_W  fetch address from pc_reg.
- ce_i  in  1  pc_reg chip enable. No fetch is started while low.
- branch_flag_i  in  1  taken branch or jump; flushes this stage.
- id_stall_i  in  1  decode cannot accept (stall[1] from ctrl).
- mem_req_o  out  1  byte read request to the memory arbiter.
- mem_a_o  out  ADDR_W  byte address for the request.
- mem_gnt_i  in  1  arbiter accepted this cycle's request.
- mem_din_i  in  8  read data, valid exactly 1 cycle after a granted request.
- inst_o  out  INST_W  assembled instruction, little-endian.
- inst_pc_o  out  ADDR_W  pc of inst_o.
- inst_valid_o  out  1  inst_o/inst_pc_o are valid for decode.
- stallreq_o  out  1  stall request to ctrl.

Behaviour:
- Reset (synchronous, active-high, any state including mid-fetch):
  - state=IDLE, issue_cnt=0, recv_cnt=0, pending=0.
  - inst_o=0, inst_pc_o=0, inst_valid_o=0, mem_req_o=0, mem_a_o=0, stallreq_o=0.
  - Data returning after reset is ignored.
- States: IDLE, FETCH, DONE.
- IDLE:
  - If ce_i && !branch_flag_i: latch fpc<=pc_i, clear counters, go to FETCH.
  - Outputs low in this state.
- FETCH:
  - mem_req_o=1 while issue_cnt<4.
  - mem_a_o=fpc+issue_cnt (combinational, ADDR_W wrap-around allowed).
  - Each cycle with mem_req_o && mem_gnt_i: issue_cnt++, pending<=1; otherwise pending<=0.
  - Each cycle with pending=1: byte[recv_cnt]<=mem_din_i, recv_cnt++.
  - When recv_cnt reaches 4: inst_o<={b3,b2,b1,b0}, inst_pc_o<=fpc, inst_valid_o<=1, go to DONE.
  - Grant withheld: issue_cnt holds and the request stays asserted with the same address. There is no timeout.
  - stallreq_o=1 throughout FETCH (combinational from state).
- Latency with continuous grant:
  - Accept at cycle 0, requests in cycles 1-4, data in cycles 2-5.
  - inst_valid_o=1 from cycle 6.
- DONE:
  - inst_valid_o=1; outputs held stable while id_stall_i=1.
  - When id_stall_i=0, decode consumes; next cycle inst_valid_o=0 and state returns to IDLE.
  - stallreq_o=0.
- Flush (branch_flag_i=1, any state except reset):
  - Next state IDLE, inst_valid_o<=0, counters cleared, pending<=0.
  - Any byte returning in the following cycle is discarded.
  - A new fetch starts no earlier than the cycle after branch_flag_i deasserts.
- Simultaneous events, in priority order: rst > branch_flag_i > id_stall_i > normal progress.
- ce_i dropping mid-fetch does not abort; only rst or branch_flag_i aborts.
- inst_valid_o is never asserted in the same cycle as mem_req_o.

Decomposition:
- Shared defines package, next to the existing Reg_Bus/Zero_Word macros:
  - `Inst_Bus`, `Mem_Byte_Bus` widths.
  - `Enabled`/`Disabled`.
  - State encodings IF_IDLE/IF_FETCH/IF_DONE.
- No sub-module. Byte assembly and counters are local; the arbiter is external.

Test Plan:
- Basic fetch: rst 2 cycles, pc_i=0x0000_1000, ce_i=1, mem_gnt_i=1, memory bytes 0x13,0x05,0x10,0x00.
  - Addresses 0x1000..0x1003 in cycles 1-4.
  - inst_o=0x0010_0513, inst_pc_o=0x1000, inst_valid_o=1 at cycle 6.
  - stallreq_o=1 in cycles 1-5 only.
- Grant gaps: mem_gnt_i low in cycles 2 and 3.
  - mem_a_o holds 0x1001 during the gap; no extra bytes captured.
  - inst_valid_o at cycle 8; same instruction value.
- Decode stall: id_stall_i=1 for 5 cycles after DONE.
  - inst_o, inst_pc_o and inst_valid_o=1 stay constant.
  - mem_req_o=0 throughout.
  - Returns to IDLE one cycle after id_stall_i=0.
- Flush mid-fetch: branch_flag_i=1 in cycle 3.
  - State IDLE next cycle; byte arriving in cycle 4 is discarded.
  - Next fetch from pc_i=0x2000 yields the correct instruction with inst_pc_o=0x2000.
- Reset mid-fetch: rst=1 in cycle 4.
  - All outputs 0 next cycle; mem_req_o=0; state IDLE.
  - A fresh fetch after rst deasserts completes normally.
- Address wrap: pc_i=0xFFFF_FFFE.
  - Addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001.
  - inst_pc_o=0xFFFF_FFFE.
